// File: rtl/puf_verifier.sv
// puf_verifier: challenge-response initiator for a ring-oscillator PUF.
// It issues NUM_CHAL LFSR-derived challenges per run and waits for each PUF
// evaluation. An enroll run stores the masked responses. A verify run
// compares fresh responses against the stored set, accumulates a saturating
// Hamming distance, and reports PASS when that distance is within THRESH.
//
// Ports:
//   i_clk           clock
//   i_rst_n         asynchronous active-low reset
//   i_start         one-cycle run request, sampled only in IDLE
//   i_enroll        mode sampled with i_start (1 = enroll, 0 = verify)
//   o_puf_challenge challenge to the PUF; the parity of successive values always alternates
//   i_puf_response  PUF response, bit 0 ignored through RESP_MASK
//   i_puf_done      PUF idle/complete (high when idle)
//   o_busy          run in progress (high exactly in non-IDLE states)
//   o_pass/o_fail/o_err  sticky, mutually exclusive result flags
//   o_enrolled      a valid enrollment is stored
//   o_hd            accumulated masked Hamming distance
module puf_verifier #(
  parameter int unsigned NUM_CHAL  = 4,
  parameter int unsigned THRESH    = 2,
  parameter logic [6:0]  SEED      = 7'h5A,
  parameter logic [7:0]  RESP_MASK = 8'hFE,
  parameter int unsigned ACK_WAIT  = 8,
  parameter int unsigned TIMEOUT   = 1_000_000,
  parameter int unsigned HD_W      = $clog2(NUM_CHAL * 8 + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_enroll,
  output logic [7:0]      o_puf_challenge,
  input  logic [7:0]      i_puf_response,
  input  logic            i_puf_done,
  output logic            o_busy,
  output logic            o_pass,
  output logic            o_fail,
  output logic            o_err,
  output logic            o_enrolled,
  output logic [HD_W-1:0] o_hd
);

  localparam int unsigned IDX_W   = (NUM_CHAL > 1) ? $clog2(NUM_CHAL) : 1;
  localparam int unsigned CNT_MAX = (TIMEOUT > ACK_WAIT) ? TIMEOUT : ACK_WAIT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitLow,
    StWaitHigh,
    StCapture,
    StNext,
    StReport
  } state_e;

  state_e          r_state;
  logic [6:0]      r_lfsr;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]      r_resp;
  logic            r_mode;      // 1 = enroll run
  logic            r_err_pend;  // run is heading to REPORT with an error
  logic [7:0]      r_chal;
  logic            r_busy;
  logic            r_pass;
  logic            r_fail;
  logic            r_err;
  logic            r_enrolled;
  logic [HD_W-1:0] r_hd;

  // Not reset: contents are only meaningful while r_enrolled is set.
  logic [7:0]      r_mem [NUM_CHAL];

  logic            w_par;
  logic [6:0]      w_lfsr_next;
  logic [3:0]      w_pop;
  logic [HD_W:0]   w_hd_sum;
  logic [HD_W-1:0] w_hd_next;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  // Choose the top bit so the new challenge's parity is the inverse of the previous one.
  assign w_par       = ~(^r_chal) ^ (^r_lfsr);
  assign w_lfsr_next = {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
  assign w_pop       = popcnt8(r_resp ^ r_mem[r_idx]);
  assign w_hd_sum    = {1'b0, r_hd} + (HD_W + 1)'(w_pop);
  assign w_hd_next   = w_hd_sum[HD_W] ? '1 : w_hd_sum[HD_W-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_lfsr     <= SEED;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_resp     <= '0;
      r_mode     <= 1'b0;
      r_err_pend <= 1'b0;
      r_chal     <= 8'h00;
      r_busy     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      r_err      <= 1'b0;
      r_enrolled <= 1'b0;
      r_hd       <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_busy <= 1'b1;
            r_pass <= 1'b0;
            r_fail <= 1'b0;
            r_err  <= 1'b0;
            r_mode <= i_enroll;
            if (!i_enroll && !r_enrolled) begin
              r_err_pend <= 1'b1;
              r_state    <= StReport;
            end else begin
              r_err_pend <= 1'b0;
              r_hd       <= '0;
              r_lfsr     <= SEED;
              r_idx      <= '0;
              r_state    <= StIssue;
            end
          end
        end
        StIssue: begin
          r_chal  <= {w_par, r_lfsr};
          r_cnt   <= '0;
          r_state <= StWaitLow;
        end
        StWaitLow: begin
          if (!i_puf_done) begin
            r_cnt   <= '0;
            r_state <= StWaitHigh;
          end else if (r_cnt == CNT_W'(ACK_WAIT - 2)) begin
            // Error flag lands ACK_WAIT edges after the challenge changed.
            r_err_pend <= 1'b1;
            r_state    <= StReport;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StWaitHigh: begin
          // DONE is checked first so a rise coinciding with expiry still wins.
          if (i_puf_done) begin
            r_resp  <= i_puf_response & RESP_MASK;
            r_state <= StCapture;
          end else if (r_cnt == CNT_W'(TIMEOUT - 2)) begin
            r_err_pend <= 1'b1;
            r_state    <= StReport;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StCapture: begin
          if (!r_mode) begin
            r_hd <= w_hd_next;
          end
          r_state <= StNext;
        end
        StNext: begin
          if (r_idx == IDX_W'(NUM_CHAL - 1)) begin
            r_state <= StReport;
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
            r_lfsr  <= w_lfsr_next;
            r_state <= StIssue;
          end
        end
        StReport: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
          if (r_err_pend) begin
            r_err <= 1'b1;
            if (r_mode) begin
              r_enrolled <= 1'b0;
            end
          end else if (r_mode) begin
            r_enrolled <= 1'b1;
            r_pass     <= 1'b1;
          end else if (r_hd <= HD_W'(THRESH)) begin
            r_pass <= 1'b1;
          end else begin
            r_fail <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Enrollment storage; verify runs never write it.
  always_ff @(posedge i_clk) begin
    if (r_state == StCapture && r_mode) begin
      r_mem[r_idx] <= r_resp;
    end
  end

  assign o_puf_challenge = r_chal;
  assign o_busy          = r_busy;
  assign o_pass          = r_pass;
  assign o_fail          = r_fail;
  assign o_err           = r_err;
  assign o_enrolled      = r_enrolled;
  assign o_hd            = r_hd;

endmodule

// File: tb/tb_puf_verifier.sv
// Directed bench for puf_verifier with a small behavioural PUF model.
module tb_puf_verifier;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       enroll;
  logic [7:0] chal;
  logic [7:0] puf_resp;
  logic       puf_done;
  logic       busy;
  logic       pass_o;
  logic       fail_o;
  logic       err_o;
  logic       enrolled;
  logic [5:0] hd;

  int checks = 0;
  int errors = 0;

  // PUF model state
  logic       puf_en;
  logic [7:0] puf_last;
  int         puf_idx;
  logic [7:0] resp_tab [4];
  logic [7:0] seen_arr [8];
  int         seen_n;
  logic [7:0] exp_ch [4];

  puf_verifier dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_start         (start),
    .i_enroll        (enroll),
    .o_puf_challenge (chal),
    .i_puf_response  (puf_resp),
    .i_puf_done      (puf_done),
    .o_busy          (busy),
    .o_pass          (pass_o),
    .o_fail          (fail_o),
    .o_err           (err_o),
    .o_enrolled      (enrolled),
    .o_hd            (hd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // PUF: starts on a challenge parity change, drops DONE 2 cycles later,
  // raises it with the next table response 3 cycles after that.
  initial begin : puf_model
    puf_done = 1'b1;
    puf_resp = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!puf_en) begin
        puf_last = chal;
      end else if (rst_n && ((^chal) != (^puf_last))) begin
        puf_last = chal;
        if (seen_n < 8) seen_arr[seen_n] = chal;
        seen_n++;
        repeat (2) @(posedge clk);
        #1 puf_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        puf_resp = resp_tab[puf_idx % 4];
        puf_done = 1'b1;
        puf_idx++;
      end
    end
  end

  task automatic pulse_start(input logic mode);
    @(negedge clk);
    start  = 1'b1;
    enroll = mode;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic do_run(input string tag, input logic mode,
                        input logic [7:0] r0, input logic [7:0] r1,
                        input logic [7:0] r2, input logic [7:0] r3,
                        input logic poke, input logic exp_pass, input logic exp_fail,
                        input logic [5:0] exp_hd);
    int n;
    resp_tab[0] = r0;
    resp_tab[1] = r1;
    resp_tab[2] = r2;
    resp_tab[3] = r3;
    puf_idx = 0;
    seen_n  = 0;
    for (int i = 0; i < 8; i++) seen_arr[i] = 8'h00;
    pulse_start(mode);
    check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
    for (n = 0; n < 300; n++) begin
      @(posedge clk);
      #1;
      if (poke && n == 5) begin
        start  = 1'b1;
        enroll = ~mode;
      end else begin
        start = 1'b0;
      end
      if (!busy) break;
    end
    start = 1'b0;
    check({tag, "_done_in_budget"}, {31'd0, busy}, 32'd0);
    check({tag, "_pass"}, {31'd0, pass_o}, {31'd0, exp_pass});
    check({tag, "_fail"}, {31'd0, fail_o}, {31'd0, exp_fail});
    check({tag, "_err"}, {31'd0, err_o}, 32'd0);
    check({tag, "_enrolled"}, {31'd0, enrolled}, 32'd1);
    check({tag, "_hd"}, {26'd0, hd}, {26'd0, exp_hd});
    check({tag, "_nchal"}, seen_n, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_chal%0d", tag, i), {24'd0, seen_arr[i]}, {24'd0, exp_ch[i]});
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin : main
    int k0;
    int k1;
    exp_ch[0] = 8'hDA;
    exp_ch[1] = 8'h35;
    exp_ch[2] = 8'h6B;
    exp_ch[3] = 8'h56;
    rst_n    = 1'b0;
    start    = 1'b0;
    enroll   = 1'b0;
    puf_en   = 1'b1;
    puf_last = 8'h00;
    puf_idx  = 0;
    seen_n   = 0;
    for (int i = 0; i < 4; i++) resp_tab[i] = 8'h00;
    for (int i = 0; i < 8; i++) seen_arr[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_chal", {24'd0, chal}, 32'h00);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pass", {31'd0, pass_o}, 32'd0);
    check("rst_fail", {31'd0, fail_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_enrolled", {31'd0, enrolled}, 32'd0);
    check("rst_hd", {26'd0, hd}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Enroll, then verifies with varying bit flips (only masked bits count).
    do_run("enroll", 1'b1, 8'hA6, 8'h3C, 8'h71, 8'hE0, 1'b0, 1'b1, 1'b0, 6'd0);
    do_run("ver_same", 1'b0, 8'hA6, 8'h3C, 8'h71, 8'hE0, 1'b0, 1'b1, 1'b0, 6'd0);
    do_run("ver_hd3", 1'b0, 8'hA4, 8'hBC, 8'h61, 8'hE0, 1'b1, 1'b0, 1'b1, 6'd3);
    do_run("ver_hd2", 1'b0, 8'hA0, 8'h3C, 8'h71, 8'hE0, 1'b0, 1'b1, 1'b0, 6'd2);
    do_run("ver_bit0", 1'b0, 8'hA7, 8'h3D, 8'h70, 8'hE1, 1'b0, 1'b1, 1'b0, 6'd0);

    // Reset while the DUT waits for DONE to rise.
    puf_idx = 0;
    pulse_start(1'b0);
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      #1;
      if (!puf_done) break;
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_chal", {24'd0, chal}, 32'h00);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_pass", {31'd0, pass_o}, 32'd0);
    check("arst_enrolled", {31'd0, enrolled}, 32'd0);
    check("arst_hd", {26'd0, hd}, 32'd0);
    puf_last = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);

    // Verify without enrollment: ERR one edge after the accepting edge.
    pulse_start(1'b0);
    check("noenr_err_early", {31'd0, err_o}, 32'd0);
    check("noenr_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("noenr_err", {31'd0, err_o}, 32'd1);
    check("noenr_busy_fall", {31'd0, busy}, 32'd0);
    check("noenr_chal", {24'd0, chal}, 32'h00);
    repeat (2) @(posedge clk);

    // Enroll with a PUF that never acknowledges.
    puf_en = 1'b0;
    k0 = -1;
    k1 = -1;
    pulse_start(1'b1);
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      #1;
      if (k0 < 0 && chal != 8'h00) k0 = n;
      if (err_o) begin
        k1 = n;
        break;
      end
    end
    check("ack_err_set", {31'd0, err_o}, 32'd1);
    check("ack_latency", k1 - k0, 32'd8);
    check("ack_chal", {24'd0, chal}, 32'hDA);
    check("ack_busy", {31'd0, busy}, 32'd0);
    check("ack_enrolled", {31'd0, enrolled}, 32'd0);
    check("ack_pass", {31'd0, pass_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/puf_verifier.md
# puf_verifier

Challenge-response initiator that drives the ring-oscillator PUF's challenge port and consumes its response/done outputs. It issues a deterministic sequence of `NUM_CHAL` challenges and waits for each PUF evaluation to complete. In ENROLL mode it stores the responses. In VERIFY mode it compares fresh responses against the stored set and reports pass/fail on an accumulated Hamming distance. It sits between the PUF instance and the system controller.

## Interface
- `NUM_CHAL`, 4: challenges per run (2..16).
- `THRESH`, 2: maximum total Hamming distance for PASS.
- `SEED`, 7'h5A: LFSR seed, nonzero.
- `RESP_MASK`, 8'hFE: response bits that take part in enroll/compare; bit 0 of the PUF response is not meaningful.
- `ACK_WAIT`, 8: cycles allowed for PUF_DONE to fall after a challenge is issued.
- `TIMEOUT`, 20'd1_000_000: cycles allowed for PUF_DONE to rise after it falls.
- `CLK` in 1: single clock.
- `RST_N` in 1: asynchronous, active-low reset.
- `START` in 1: one-cycle request. Sampled only in IDLE.
- `ENROLL` in 1: mode, sampled with START. 1 = enroll, 0 = verify.
- `PUF_CHALLENGE` out 8: challenge driven to the PUF.
- `PUF_RESPONSE` in 8: PUF response.
- `PUF_DONE` in 1: PUF idle/complete, high when idle.
- `BUSY` out 1: run in progress.
- `PASS`, `FAIL`, `ERR` out 1 each: sticky result flags. At most one of them is set.
- `ENROLLED` out 1: a valid enrollment is stored.
- `HD` out HD_W: accumulated masked Hamming distance. HD_W = $clog2(NUM_CHAL*8+1), which is 6 by default.

## Operation
- **LFSR:** 7-bit, x^7+x^6+1, shift left, new bit0 = b6^b5. Loaded with SEED on every accepted START, advanced once per challenge.
- **Challenge:** `PUF_CHALLENGE = {p, lfsr}`, with p chosen so that ^PUF_CHALLENGE differs from ^ of the previous PUF_CHALLENGE value. The PUF starts only on a parity change, so consecutive challenges, including across runs, always alternate parity.
- **States:**
  - IDLE
    - START with ENROLL=0 and ENROLLED=0: go to REPORT with ERR.
    - Otherwise, START: go to ISSUE. Clear PASS/FAIL/ERR/HD, load LFSR, idx=0.
  - ISSUE: drive the new challenge (registered) and go to WAIT_LOW.
  - WAIT_LOW
    - PUF_DONE==0: go to WAIT_HIGH.
    - ACK_WAIT cycles elapse: go to REPORT with ERR.
  - WAIT_HIGH
    - PUF_DONE==1: go to CAPTURE.
    - TIMEOUT cycles elapse: go to REPORT with ERR.
  - CAPTURE: register `PUF_RESPONSE & RESP_MASK`.
    - Enroll: write mem[idx].
    - Verify: HD += popcount(resp ^ mem[idx]).
    - Then go to NEXT.
  - NEXT
    - idx==NUM_CHAL-1: go to REPORT.
    - Otherwise: idx++, advance LFSR, go to ISSUE.
  - REPORT: go to IDLE.
    - Enroll: set ENROLLED and PASS.
    - Verify: PASS if HD<=THRESH, else FAIL.
- **Response memory:** NUM_CHAL x 8 register array; not reset.
  - An enroll run that ends in ERR clears ENROLLED.
  - A verify run never modifies the memory.
- **HD:** saturates at its maximum; no wrap.
- **Reset / hold:**
  - PUF_CHALLENGE holds its last value in IDLE.
  - RST_N low at any point forces IDLE and clears ENROLLED. Stored memory contents are then invalid.

## Timing
- **Reset values:** PUF_CHALLENGE=8'h00, BUSY=0, PASS=0, FAIL=0, ERR=0, ENROLLED=0, HD=0; state IDLE, LFSR=SEED.
- **BUSY:**
  - Rises the cycle after START is accepted.
  - Falls in the same cycle that PASS/FAIL/ERR is set.
  - Is high exactly in the non-IDLE states.
- **Challenge issue:** PUF_CHALLENGE changes on the edge leaving ISSUE. The ACK_WAIT count starts on the following cycle.
- **Capture:** PUF_RESPONSE is sampled on the first CLK edge where PUF_DONE is seen high after being low, and never earlier.
- **Result flags:**
  - Set on the edge leaving REPORT.
  - Remain stable until the next accepted START or reset.
  - START while BUSY=1 is ignored.
- **Latency:** per challenge = 1 (ISSUE) + low wait + high wait + 1 (CAPTURE) + 1 (NEXT); plus 1 cycle for REPORT.
- **Simultaneous START and reset:** reset wins.
- **Simultaneous PUF_DONE rise and timeout expiry:** the DONE rise wins.

## Test plan
- **Enroll then verify, identical responses:** PUF model returns 8'hA6, 8'h3C, 8'h71, 8'hE0. ENROLL=1 START, then ENROLL=0 START. Required: PASS=1 both runs, HD=0, ENROLLED=1, four challenges per run with alternating parity.
- **Verify with 3 flipped masked bits across challenges** (THRESH=2): FAIL=1, HD=3. With only 2 flipped bits: PASS=1, HD=2.
- **Verify with only bit 0 differing on every response:** PASS=1, HD=0 (RESP_MASK).
- **PUF_DONE never falls after ISSUE:** ERR=1 exactly ACK_WAIT cycles after the challenge changes, BUSY=0. For an enroll run, ENROLLED=0 afterwards.
- **Verify START with ENROLLED=0:** ERR=1 two cycles after START, PUF_CHALLENGE unchanged.
- **RST_N asserted mid-run in WAIT_HIGH:** all outputs return to reset values immediately (asynchronous). A later verify START gives ERR.
